// File: rtl/arb_requester_if.sv
// arb_requester_if: client command, local source, arbiter req/grant and shared
// bus signals of one requester agent.
//   master : the requester agent (arb_requester)
//   slave  : the environment (client, source, arbiter, bus observer)
interface arb_requester_if #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [LEN_W-1:0]  cmd_len;
  logic [DATA_W-1:0] src_data;
  logic              src_empty;
  logic              src_rd;
  logic              req;
  logic              grant;
  logic              bus_valid;
  logic [DATA_W-1:0] bus_data;
  logic              bus_last;
  logic              done;
  logic              timeout_err;
  logic              abort_err;

  modport master (
    input  cmd_valid, cmd_len, src_data, src_empty, grant,
    output cmd_ready, src_rd, req, bus_valid, bus_data, bus_last,
           done, timeout_err, abort_err
  );

  modport slave (
    output cmd_valid, cmd_len, src_data, src_empty, grant,
    input  cmd_ready, src_rd, req, bus_valid, bus_data, bus_last,
           done, timeout_err, abort_err
  );
endinterface

// File: rtl/arb_requester.sv
// arb_requester: requester-side agent for a fixed-priority Moore arbiter.
// Takes a burst command, raises req, moves cmd_len+1 beats from the local
// source to the shared bus while granted, then drops req and waits for grant
// to fall before accepting the next command.
// Ports:
//   CLK, RESET : clock, synchronous active-high reset
//   rq         : arb_requester_if.master (command, source, req/grant, bus,
//                done/timeout_err/abort_err status pulses)
module arb_requester #(
  parameter int DATA_W  = 8,
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic           CLK,
  input  logic           RESET,
  arb_requester_if.master rq
);
  localparam int WCNT_W = $clog2(TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, XFER, RELEASE} state_t;

  state_t            state;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  beat_cnt;
  logic [WCNT_W-1:0] wait_cnt;
  logic              done_q, tmo_q, abt_q;
  logic              beat, last_beat;

  // A beat is decided in the same cycle it is seen: XFER, still granted,
  // and the source has a word.
  assign beat      = (state == XFER) && rq.grant && !rq.src_empty;
  assign last_beat = beat && (beat_cnt == len_q);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      len_q    <= '0;
      beat_cnt <= '0;
      wait_cnt <= '0;
      done_q   <= 1'b0;
      tmo_q    <= 1'b0;
      abt_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      tmo_q  <= 1'b0;
      abt_q  <= 1'b0;
      case (state)
        IDLE: if (rq.cmd_valid) begin
          len_q    <= rq.cmd_len;
          beat_cnt <= '0;
          wait_cnt <= '0;
          state    <= REQ;
        end
        REQ: begin
          // grant on the timeout boundary cycle still wins
          if (rq.grant) begin
            wait_cnt <= '0;
            state    <= XFER;
          end else if (wait_cnt == WAIT_LAST) begin
            tmo_q <= 1'b1;
            state <= RELEASE;
          end else if (wait_cnt != {WCNT_W{1'b1}}) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        XFER: begin
          if (!rq.grant) begin
            abt_q <= 1'b1;
            state <= RELEASE;
          end else if (last_beat) begin
            done_q <= 1'b1;
            state  <= RELEASE;
          end else if (beat) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        RELEASE: if (!rq.grant) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign rq.cmd_ready   = (state == IDLE);
  assign rq.req         = (state == REQ) || (state == XFER);
  assign rq.bus_valid   = beat;
  assign rq.src_rd      = beat;
  assign rq.bus_data    = beat ? rq.src_data : '0;
  assign rq.bus_last    = last_beat;
  assign rq.done        = done_q;
  assign rq.timeout_err = tmo_q;
  assign rq.abort_err   = abt_q;
endmodule

// File: tb/tb_arb_requester.sv
module tb_arb_requester;
  logic CLK = 1'b0;
  logic RESET, arb_rst;
  always #5 CLK = ~CLK;

  arb_requester_if #(.DATA_W(8), .LEN_W(4)) ifa();
  arb_requester_if #(.DATA_W(8), .LEN_W(4)) ifb();
  arb_requester_if #(.DATA_W(8), .LEN_W(4)) ift();

  arb_requester #(.DATA_W(8), .LEN_W(4), .TIMEOUT(255)) u_a (.CLK(CLK), .RESET(RESET), .rq(ifa));
  arb_requester #(.DATA_W(8), .LEN_W(4), .TIMEOUT(255)) u_b (.CLK(CLK), .RESET(RESET), .rq(ifb));
  arb_requester #(.DATA_W(8), .LEN_W(4), .TIMEOUT(8))   u_t (.CLK(CLK), .RESET(RESET), .rq(ift));

  // 4-way fixed-priority Moore arbiter model: grant registered, held while the
  // owner's req stays high, one empty cycle after the owner drops req.
  logic [3:0] arb_req, arb_gnt;
  logic       own_v;
  logic [1:0] own;
  assign arb_req = {2'b00, ifb.req, ifa.req};
  assign arb_gnt = own_v ? (4'b0001 << own) : 4'b0000;
  always @(posedge CLK) begin
    if (arb_rst) own_v <= 1'b0;
    else if (!own_v) begin
      if (arb_req[0])      begin own_v <= 1'b1; own <= 2'd0; end
      else if (arb_req[1]) begin own_v <= 1'b1; own <= 2'd1; end
      else if (arb_req[2]) begin own_v <= 1'b1; own <= 2'd2; end
      else if (arb_req[3]) begin own_v <= 1'b1; own <= 2'd3; end
    end else if (!arb_req[own]) own_v <= 1'b0;
  end

  logic force_lo;
  assign ifa.grant = arb_gnt[0] & ~force_lo;
  assign ifb.grant = arb_gnt[1];
  assign ift.grant = 1'b0;

  // sources: incrementing words, advanced on src_rd
  logic       src_clr;
  logic [7:0] a_idx, b_idx;
  always @(posedge CLK) begin
    if (src_clr) begin a_idx <= 8'd0; b_idx <= 8'd0; end
    else begin
      if (ifa.src_rd) a_idx <= a_idx + 8'd1;
      if (ifb.src_rd) b_idx <= b_idx + 8'd1;
    end
  end
  assign ifa.src_data = 8'hA0 + a_idx;
  assign ifb.src_data = 8'hB0 + b_idx;
  assign ift.src_data = 8'h5A;

  wire [15:0] obs_a = {ifa.req, ifa.cmd_ready, ifa.bus_valid, ifa.bus_last, ifa.src_rd,
                       ifa.done, ifa.timeout_err, ifa.abort_err, ifa.bus_data};
  wire [15:0] obs_b = {ifb.req, ifb.cmd_ready, ifb.bus_valid, ifb.bus_last, ifb.src_rd,
                       ifb.done, ifb.timeout_err, ifb.abort_err, ifb.bus_data};
  wire [15:0] obs_t = {ift.req, ift.cmd_ready, ift.bus_valid, ift.bus_last, ift.src_rd,
                       ift.done, ift.timeout_err, ift.abort_err, ift.bus_data};

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // expected observation vector; src_rd tracks bus_valid, data is 0 off-beat
  function automatic logic [15:0] ev(input logic rqv, rdy, bv, last, dn, to, ab,
                                     input logic [7:0] d);
    return {rqv, rdy, bv, last, bv, dn, to, ab, (bv ? d : 8'h00)};
  endfunction

  task automatic next_cyc();
    @(posedge CLK); #1;
  endtask

  task automatic gap(input int n);
    src_clr = 1'b1;
    for (int i = 0; i < n; i++) next_cyc();
    src_clr = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; arb_rst = 1'b1; force_lo = 1'b0; src_clr = 1'b1;
    ifa.cmd_valid = 1'b0; ifa.cmd_len = '0; ifa.src_empty = 1'b0;
    ifb.cmd_valid = 1'b0; ifb.cmd_len = '0; ifb.src_empty = 1'b0;
    ift.cmd_valid = 1'b0; ift.cmd_len = '0; ift.src_empty = 1'b0;
    repeat (3) next_cyc();
    @(negedge CLK);
    chk("rst a", obs_a, ev(0, 1, 0, 0, 0, 0, 0, 8'h00));
    chk("rst b", obs_b, ev(0, 1, 0, 0, 0, 0, 0, 8'h00));
    chk("rst t", obs_t, ev(0, 1, 0, 0, 0, 0, 0, 8'h00));
    next_cyc();
    RESET = 1'b0; arb_rst = 1'b0;
    gap(3);

    // basic 4-beat burst
    for (int c = 0; c <= 11; c++) begin
      ifa.cmd_valid = (c == 0); ifa.cmd_len = 4'd3;
      @(negedge CLK);
      chk($sformatf("basic c%0d", c), obs_a,
          ev(c >= 1 && c <= 6, c == 0 || c >= 9, c >= 3 && c <= 6, c == 6,
             c == 7, 0, 0, 8'(8'hA0 + c - 3)));
      next_cyc();
    end
    gap(4);

    // source stall for 2 cycles after grant
    for (int c = 0; c <= 11; c++) begin
      ifa.cmd_valid = (c == 0); ifa.cmd_len = 4'd1;
      ifa.src_empty = (c == 3 || c == 4);
      @(negedge CLK);
      chk($sformatf("stall c%0d", c), obs_a,
          ev(c >= 1 && c <= 6, c == 0 || c >= 9, c == 5 || c == 6, c == 6,
             c == 7, 0, 0, 8'(8'hA0 + c - 5)));
      next_cyc();
    end
    ifa.src_empty = 1'b0;
    gap(4);

    // grant lost after 3 beats of an 8-beat burst
    for (int c = 0; c <= 11; c++) begin
      ifa.cmd_valid = (c == 0); ifa.cmd_len = 4'd7;
      force_lo = (c >= 6);
      @(negedge CLK);
      chk($sformatf("loss c%0d", c), obs_a,
          ev(c >= 1 && c <= 6, c == 0 || c >= 8, c >= 3 && c <= 5, 0,
             0, 0, c == 7, 8'(8'hA0 + c - 3)));
      next_cyc();
    end
    force_lo = 1'b0;
    gap(4);

    // timeout with grant tied low, TIMEOUT=8
    for (int c = 0; c <= 12; c++) begin
      ift.cmd_valid = (c == 0); ift.cmd_len = 4'd2;
      @(negedge CLK);
      chk($sformatf("tmo c%0d", c), obs_t,
          ev(c >= 1 && c <= 8, c == 0 || c >= 10, 0, 0, 0, c == 9, 0, 8'h00));
      next_cyc();
    end
    gap(4);

    // two requesters on slots 0 and 1
    for (int c = 0; c <= 15; c++) begin
      ifa.cmd_valid = (c == 0); ifa.cmd_len = 4'd2;
      ifb.cmd_valid = (c == 0); ifb.cmd_len = 4'd2;
      @(negedge CLK);
      chk($sformatf("cont a c%0d", c), obs_a,
          ev(c >= 1 && c <= 5, c == 0 || c >= 8, c >= 3 && c <= 5, c == 5,
             c == 6, 0, 0, 8'(8'hA0 + c - 3)));
      chk($sformatf("cont b c%0d", c), obs_b,
          ev(c >= 1 && c <= 11, c == 0 || c >= 14, c >= 9 && c <= 11, c == 11,
             c == 12, 0, 0, 8'(8'hB0 + c - 9)));
      chk($sformatf("cont gnt1 c%0d", c), 32'(ifb.grant), 32'(c >= 8 && c <= 12));
      chk($sformatf("cont ovl c%0d", c), 32'(ifa.bus_valid & ifb.bus_valid), 32'd0);
      next_cyc();
    end
    gap(4);

    // reset mid-XFER: held 3 cycles, command dropped silently
    for (int c = 0; c <= 10; c++) begin
      ifa.cmd_valid = (c == 0); ifa.cmd_len = 4'd7;
      RESET = (c >= 5 && c <= 7);
      @(negedge CLK);
      if (c <= 5)
        chk($sformatf("midrst c%0d", c), obs_a,
            ev(c >= 1, c == 0, c >= 3, 0, 0, 0, 0, 8'(8'hA0 + c - 3)));
      else
        chk($sformatf("midrst c%0d", c), obs_a, ev(0, 1, 0, 0, 0, 0, 0, 8'h00));
      next_cyc();
    end
    RESET = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
